bitty_core: RTL and testbench

- Sequential, parametrised successor to the BittyPro combinational datapath.
- Holds an internal 8-entry register file and accepts one 16-bit instruction at a time over a valid/ready handshake.
- Executes each instruction through a four-state FSM and writes the ALU result back to the register file.
- Sits between the instruction source (testbench or future fetch unit) and the register file, and exposes a load port and a debug read port.

---
 rtl/bitty_core.sv | 159 +++++++++++++++
 tb/tb_bitty_core.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_core.sv
// bitty_core: sequential multi-cycle core with an 8-entry register file.
// Takes one 16-bit instruction per valid/ready handshake and runs it through
// IDLE -> READ -> EXEC -> WB. An accepted instruction retires three cycles
// after its handshake. A new instruction can be accepted every four cycles.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   inst, inst_valid     instruction word and its valid strobe
//   inst_ready           high in S_IDLE when no load is requested
//   ld_en/ld_addr/ld_data  register-file load port (honoured in S_IDLE only)
//   dbg_addr, dbg_data   combinational register-file read port
//   out, cout, comp, lt  registered ALU result and flags of the last instruction
//   done                 one-cycle pulse when an instruction retires
//
// Instruction word: [15:13] rx, [12:10] ry, [12:5] imm, [4:2] op, [1:0] fmt.
// fmt 00: rx op ry -> rx. fmt 01: rx op imm -> rx.
// fmt 10: compare only. fmt 11: nop.

module bitty_core #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       inst,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic              ld_en,
   input  logic [2:0]        ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] out,
   output logic              cout,
   output logic              comp,
   output logic              lt,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t state_q, state_d;

   logic [15:0]       inst_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] out_q;
   logic              cout_q, comp_q, lt_q;

   // Fields of the latched instruction
   logic [2:0]        rx, ry, op;
   logic [1:0]        fmt;
   logic [DATA_W-1:0] imm_ext;

   assign rx      = inst_q[15:13];
   assign ry      = inst_q[12:10];
   assign op      = inst_q[4:2];
   assign fmt     = inst_q[1:0];
   assign imm_ext = {{(DATA_W-8){1'b0}}, inst_q[12:5]};

   // ALU
   logic [DATA_W:0]   sum, diff;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   assign sum   = {1'b0, a_q} + {1'b0, b_q};
   // diff[DATA_W] is the borrow; no-borrow (A >= B) is its inverse
   assign diff  = {1'b0, a_q} - {1'b0, b_q};
   assign shamt = b_q[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      if (fmt == 2'b10) begin
         // Compare reports A-B with sub's carry regardless of op
         alu_res = diff[DATA_W-1:0];
         alu_c   = ~diff[DATA_W];
      end else begin
         case (op)
            3'd0: begin
               alu_res = sum[DATA_W-1:0];
               alu_c   = sum[DATA_W];
            end
            3'd1: begin
               alu_res = diff[DATA_W-1:0];
               alu_c   = ~diff[DATA_W];
            end
            3'd2:    alu_res = a_q & b_q;
            3'd3:    alu_res = a_q | b_q;
            3'd4:    alu_res = a_q ^ b_q;
            3'd5:    alu_res = ~a_q;
            3'd6:    alu_res = a_q << shamt;
            3'd7:    alu_res = a_q >> shamt;
            default: alu_res = '0;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!ld_en && inst_valid) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         comp_q  <= 1'b0;
         lt_q    <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               // A load takes priority and blocks acceptance this cycle
               if (ld_en)           regs_q[ld_addr] <= ld_data;
               else if (inst_valid) inst_q <= inst;
            end
            S_READ: begin
               a_q <= regs_q[rx];
               b_q <= (fmt == 2'b01) ? imm_ext : regs_q[ry];
            end
            S_EXEC: begin
               if (fmt != 2'b11) begin
                  out_q  <= alu_res;
                  cout_q <= alu_c;
                  comp_q <= (a_q == b_q);
                  lt_q   <= (a_q < b_q);
               end
            end
            S_WB: begin
               if (!fmt[1]) regs_q[rx] <= out_q;
            end
            default: ;
         endcase
      end
   end

   assign inst_ready = (state_q == S_IDLE) && !ld_en;
   assign done       = (state_q == S_WB);
   assign dbg_data   = regs_q[dbg_addr];
   assign out        = out_q;
   assign cout       = cout_q;
   assign comp       = comp_q;
   assign lt         = lt_q;

endmodule

// File: tb/tb_bitty_core.sv
// Scoreboard bench for bitty_core: stimulus pushes model predictions, a
// monitor pops and compares them whenever done pulses.

module tb_bitty_core;

   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       inst;
   logic              inst_valid;
   logic              inst_ready;
   logic              ld_en;
   logic [2:0]        ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [2:0]        dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic [DATA_W-1:0] out;
   logic              cout, comp, lt, done;

   bitty_core #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .out        (out),
      .cout       (cout),
      .comp       (comp),
      .lt         (lt),
      .done       (done)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [15:0] out;
      logic        cout;
      logic        comp;
      logic        lt;
      int          done_cyc;
   } exp_t;

   exp_t sb_q[$];

   // Reference state
   logic [15:0] m_regs [8];
   logic [15:0] m_out;
   logic        m_cout, m_comp, m_lt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_out  = 16'h0;
      m_cout = 1'b0;
      m_comp = 1'b0;
      m_lt   = 1'b0;
   endtask

   // Architectural effect of one instruction, then queue the expected outputs
   task automatic model_exec(input logic [15:0] w, input int done_cyc);
      logic [2:0]  rx, ry, op;
      logic [1:0]  fmt;
      int unsigned a, b, r, amt;
      logic        c;
      exp_t        e;
      rx  = w[15:13];
      ry  = w[12:10];
      op  = w[4:2];
      fmt = w[1:0];
      if (fmt != 2'b11) begin
         a   = {16'd0, m_regs[rx]};
         b   = (fmt == 2'b01) ? {24'd0, w[12:5]} : {16'd0, m_regs[ry]};
         amt = b % 16;
         c   = 1'b0;
         r   = 0;
         if (fmt == 2'b10 || op == 3'd1) begin
            r = (a + 65536 - b) % 65536;
            c = (a >= b);
         end else begin
            case (op)
               3'd0: begin
                  r = (a + b) % 65536;
                  c = ((a + b) >= 65536);
               end
               3'd2:    r = a & b;
               3'd3:    r = a | b;
               3'd4:    r = a ^ b;
               3'd5:    r = 65535 - a;
               3'd6:    r = (a << amt) % 65536;
               3'd7:    r = a >> amt;
               default: r = 0;
            endcase
         end
         m_out  = r[15:0];
         m_cout = c;
         m_comp = (a == b);
         m_lt   = (a < b);
         if (!fmt[1]) m_regs[rx] = r[15:0];
      end
      e.out      = m_out;
      e.cout     = m_cout;
      e.comp     = m_comp;
      e.lt       = m_lt;
      e.done_cyc = done_cyc;
      sb_q.push_back(e);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(sb_q.size()), 1);
         end else begin
            e = sb_q.pop_front();
            chk("out",          32'(out),  32'(e.out));
            chk("cout",         32'(cout), 32'(e.cout));
            chk("comp",         32'(comp), 32'(e.comp));
            chk("lt",           32'(lt),   32'(e.lt));
            chk("done_latency", 32'(cyc),  32'(e.done_cyc));
         end
      end
   end

   function automatic logic [15:0] mk(input logic [2:0] rx, input logic [2:0] ry,
                                      input logic [2:0] op, input logic [1:0] fmt);
      return {rx, ry, 5'd0, op, fmt};
   endfunction

   function automatic logic [15:0] mk_imm(input logic [2:0] rx, input logic [7:0] imm,
                                          input logic [2:0] op, input logic [1:0] fmt);
      return {rx, imm, op, fmt};
   endfunction

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en    = 1'b0;
      m_regs[a] = d;
   endtask

   // Returns at the negedge of the READ cycle (acc = cycle count after accept)
   task automatic issue(input logic [15:0] w, input bit push, output int acc);
      int k;
      @(negedge clk);
      inst       = w;
      inst_valid = 1'b1;
      ld_en      = 1'b0;
      #1;
      k = 0;
      while (!inst_ready && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (!inst_ready) begin
         chk("accept_timeout", 32'(inst_ready), 1);
         inst_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (push) model_exec(w, acc + 2);
      inst_valid = 1'b0;
      inst       = 16'($urandom);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (sb_q.size() != 0) begin
         chk("retire_timeout", 32'(sb_q.size()), 0);
         sb_q.delete();
      end
      @(negedge clk);
      #2;
   endtask

   task automatic check_regs();
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk($sformatf("reg_r%0d", i), 32'(dbg_data), 32'(m_regs[i]));
      end
   endtask

   task automatic dbg_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      chk(name, 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev, c0, k;
      logic [15:0] w;
      reset      = 1'b1;
      inst       = 16'h0;
      inst_valid = 1'b0;
      ld_en      = 1'b0;
      ld_addr    = 3'd0;
      ld_data    = 16'h0;
      dbg_addr   = 3'd0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_inst_ready", 32'(inst_ready), 1);
      chk("rst_out",        32'(out),        0);
      chk("rst_flags",      32'({cout, comp, lt}), 0);
      chk("rst_done",       32'(done),       0);
      check_regs();

      // add r1,r2; a load pulsed while busy must be ignored
      load(3'd1, 16'h0005);
      load(3'd2, 16'h0003);
      issue(mk(3'd1, 3'd2, 3'd0, 2'b00), 1'b1, acc);
      ld_en   = 1'b1;
      ld_addr = 3'd0;
      ld_data = 16'hABCD;
      @(negedge clk);
      ld_en = 1'b0;
      wait_idle();
      dbg_chk("add_r1", 3'd1, 16'h0008);
      check_regs();

      // carry out of add, then sub with no borrow
      load(3'd3, 16'hFFFF);
      load(3'd4, 16'h0001);
      issue(mk(3'd3, 3'd4, 3'd0, 2'b00), 1'b1, acc);
      issue(mk(3'd4, 3'd3, 3'd1, 2'b00), 1'b1, acc);
      wait_idle();
      dbg_chk("add_wrap_r3", 3'd3, 16'h0000);

      // immediate xor then shift
      load(3'd5, 16'h00F0);
      issue(mk_imm(3'd5, 8'hFF, 3'd4, 2'b01), 1'b1, acc);
      wait_idle();
      dbg_chk("xor_imm_r5", 3'd5, 16'h000F);
      issue(mk_imm(3'd5, 8'h04, 3'd6, 2'b01), 1'b1, acc);
      wait_idle();
      dbg_chk("shl_imm_r5", 3'd5, 16'h00F0);

      // compares (op field irrelevant), then a nop keeps flags
      load(3'd6, 16'h0002);
      load(3'd7, 16'h0009);
      issue(mk(3'd6, 3'd7, 3'd3, 2'b10), 1'b1, acc);
      issue(mk(3'd6, 3'd6, 3'd0, 2'b10), 1'b1, acc);
      issue(mk(3'd6, 3'd7, 3'd2, 2'b11), 1'b1, acc);
      wait_idle();
      dbg_chk("cmp_r6_kept", 3'd6, 16'h0002);
      check_regs();

      // load and valid together: load wins, accept on the first ld_en-low cycle,
      // then a held valid retires once every 4 cycles
      w = mk(3'd1, 3'd2, 3'd0, 2'b00);
      @(negedge clk);
      ld_en      = 1'b1;
      ld_addr    = 3'd2;
      ld_data    = 16'h0011;
      inst       = w;
      inst_valid = 1'b1;
      #1;
      chk("ld_blocks_ready", 32'(inst_ready), 0);
      @(negedge clk);
      #1;
      chk("ld_blocks_ready2", 32'(inst_ready), 0);
      @(negedge clk);
      ld_en     = 1'b0;
      m_regs[2] = 16'h0011;
      c0 = cyc;
      #1;
      prev = -1;
      for (int j = 0; j < 3; j++) begin
         k = 0;
         while (!inst_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
         end
         if (!inst_ready) begin
            chk("held_accept_timeout", 32'(inst_ready), 1);
            break;
         end
         @(posedge clk);
         @(negedge clk);
         acc = cyc;
         model_exec(w, acc + 2);
         if (j == 0) chk("accept_after_load", 32'(acc), 32'(c0 + 1));
         else        chk("accept_spacing",    32'(acc - prev), 4);
         prev = acc;
         #1;
      end
      inst_valid = 1'b0;
      wait_idle();
      check_regs();

      // reset while add r1,r2 sits in S_EXEC: discarded, no done, all cleared
      issue(mk(3'd1, 3'd2, 3'd0, 2'b00), 1'b0, acc);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_out",  32'(out),  0);
      chk("midrst_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("postrst_inst_ready", 32'(inst_ready), 1);
      chk("postrst_flags",      32'({cout, comp, lt}), 0);
      repeat (5) @(negedge clk);
      check_regs();

      // randomized mix of loads and instructions
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            load(3'($urandom_range(0, 7)), 16'($urandom));
         end else begin
            issue(16'($urandom), 1'b1, acc);
         end
         if (i % 20 == 19) begin
            wait_idle();
            check_regs();
         end
      end
      wait_idle();
      check_regs();
      chk("scoreboard_empty", 32'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
